irq_request_latch: RTL and testbench

- Upstream request stage for the 4-to-2 priority encoder.
- Synchronises four asynchronous interrupt lines, detects rising edges and holds them in a pending register.
- Drives the masked pending vector into the encoder, takes the encoder's index/valid back, and runs a req/ack handshake toward the consumer.
- Clears the serviced bit on acknowledge.

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_edge_sync.sv | 27 ++
 rtl/irq_request_latch.sv | 97 +++++++++
 tb/tb_irq_request_latch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt request latch.
package irq_pkg;

   localparam int N_IRQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      SETTLE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_edge_sync.sv
// One request line: synchroniser chain, previous-value flop and rising-edge pulse.
module irq_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   prev;

   // Chain resets low, so a line already high at reset release reads as an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_chain <= '0;
         prev       <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
         prev       <= sync_chain[SYNC_STAGES-1];
      end
   end

   assign rise = sync_chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/irq_request_latch.sv
// Edge-latching interrupt request stage with req/ack handshake toward the consumer.
// Optional sticky overrun flags are built when IRQ_OVERRUN_EN is defined.
module irq_request_latch #(
   parameter int N_IRQ       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_IRQ-1:0]         irq_in,
   input  logic [N_IRQ-1:0]         irq_mask,
   output logic [N_IRQ-1:0]         pend_o,
   input  logic [$clog2(N_IRQ)-1:0] enc_idx,
   input  logic                     enc_valid,
   output logic                     irq_req,
   output logic [$clog2(N_IRQ)-1:0] irq_id,
   input  logic                     irq_ack
`ifdef IRQ_OVERRUN_EN
   ,
   output logic [N_IRQ-1:0]         overrun_o,
   input  logic                     overrun_clr
`endif
);
   import irq_pkg::*;

   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] clr_vec;
   irq_state_e       state_q, state_d;
   logic             req_d;
   logic [IDX_W-1:0] id_d;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
      irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (irq_in[i]),
         .rise  (rise[i])
      );
   end

   // A new edge in the same cycle as the ack clear keeps the bit pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~clr_vec) | rise;
   end

   assign pend_o = pending & ~irq_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         irq_req <= 1'b0;
         irq_id  <= '0;
      end else begin
         state_q <= state_d;
         irq_req <= req_d;
         irq_id  <= id_d;
      end
   end

   // irq_id is captured once in IDLE and frozen until the ack.
   always_comb begin
      state_d = state_q;
      req_d   = irq_req;
      id_d    = irq_id;
      clr_vec = '0;
      unique case (state_q)
         IDLE: begin
            if (enc_valid) begin
               id_d    = enc_idx;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (irq_ack) begin
               clr_vec[irq_id] = 1'b1;
               req_d           = 1'b0;
               state_d         = SETTLE;
            end
         end
         SETTLE:  state_d = IDLE;
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

`ifdef IRQ_OVERRUN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overrun_o <= '0;
      else        overrun_o <= (overrun_clr ? '0 : overrun_o) | (rise & pending);
   end
`endif

endmodule

// File: tb/tb_irq_request_latch.sv
// Scoreboard bench for irq_request_latch; the encoder is modelled here as a highest-index-wins priority encoder.
module tb_irq_request_latch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] irq_in;
   logic [3:0] irq_mask;
   logic [3:0] pend_o;
   logic [1:0] enc_idx;
   logic       enc_valid;
   logic       irq_req;
   logic [1:0] irq_id;
   logic       irq_ack;
`ifdef IRQ_OVERRUN_EN
   logic [3:0] overrun_o;
   logic       overrun_clr;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   irq_request_latch #(.N_IRQ(4), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_in      (irq_in),
      .irq_mask    (irq_mask),
      .pend_o      (pend_o),
      .enc_idx     (enc_idx),
      .enc_valid   (enc_valid),
      .irq_req     (irq_req),
      .irq_id      (irq_id),
      .irq_ack     (irq_ack)
`ifdef IRQ_OVERRUN_EN
      ,
      .overrun_o   (overrun_o),
      .overrun_clr (overrun_clr)
`endif
   );

   always_comb begin
      enc_valid = |pend_o;
      enc_idx   = 2'd0;
      for (int i = 0; i < 4; i++)
         if (pend_o[i]) enc_idx = i[1:0];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_lines();
      irq_in = 4'b0000;
      repeat (4) step();
   endtask

   // Waits (bounded) for irq_req, then pops the scoreboard and compares the id.
   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (irq_req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check_val({tag, "_req"}, irq_req, 1);
      if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, exp_q.size(), 1);
      else                   check_val({tag, "_id"}, irq_id, exp_q.pop_front());
   endtask

   task automatic ack_now(input string tag);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check_val({tag, "_drop"}, irq_req, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      irq_in   = 4'b0000;
      irq_mask = 4'b0000;
      irq_ack  = 1'b0;
`ifdef IRQ_OVERRUN_EN
      overrun_clr = 1'b0;
`endif
      repeat (3) step();
      check_val("rst_req", irq_req, 0);
      check_val("rst_pend", pend_o, 0);
      check_val("rst_id", irq_id, 0);
`ifdef IRQ_OVERRUN_EN
      check_val("rst_ovr", overrun_o, 0);
`endif
      rst_n = 1'b1;
      repeat (2) step();

      // single line 2: latency of pend_o and irq_req
      irq_in = 4'b0100;
      exp_q.push_back(2);
      step();
      check_val("t1_pend_k", pend_o, 4'b0000);
      step();
      check_val("t1_pend_k1", pend_o, 4'b0000);
      step();
      check_val("t1_pend_k2", pend_o, 4'b0100);
      check_val("t1_req_k2", irq_req, 0);
      step();
      check_val("t1_req_k3", irq_req, 1);
      check_val("t1_id", irq_id, exp_q.pop_front());
      ack_now("t1");
      check_val("t1_pend_clr", pend_o, 4'b0000);
      drop_lines();
      check_val("t1_idle", irq_req, 0);

      // lines 0 and 3 together: 3 first, then 0 after SETTLE
      irq_in = 4'b1001;
      exp_q.push_back(3);
      exp_q.push_back(0);
      wait_req("t2a");
      ack_now("t2a");
      step();
      check_val("t2_settle", irq_req, 0);
      step();
      check_val("t2b_req", irq_req, 1);
      check_val("t2b_id", irq_id, exp_q.pop_front());
      ack_now("t2b");
      drop_lines();

      // masked line latches but does not request until unmasked
      irq_mask = 4'b1000;
      irq_in   = 4'b1000;
      repeat (5) step();
      check_val("t3_pend_masked", pend_o, 4'b0000);
      check_val("t3_no_req", irq_req, 0);
      irq_mask = 4'b0000;
      exp_q.push_back(3);
      wait_req("t3");
      irq_mask = 4'b1111;
      step();
      check_val("t3_hold_req", irq_req, 1);
      check_val("t3_hold_id", irq_id, 3);
      ack_now("t3");
      irq_mask = 4'b0000;
      #1;
      check_val("t3_pend_clr", pend_o, 4'b0000);
      drop_lines();

      // re-edge on line 1 coincident with its ack: set wins
      irq_in = 4'b0010;
      exp_q.push_back(1);
      wait_req("t4a");
      irq_in = 4'b0000;
      repeat (3) step();
      irq_in = 4'b0010;
      exp_q.push_back(1);
      repeat (2) step();
      check_val("t4_idhold", irq_id, 1);
      ack_now("t4a");
      check_val("t4_pend_kept", pend_o, 4'b0010);
      wait_req("t4b");
      ack_now("t4b");
      drop_lines();

`ifdef IRQ_OVERRUN_EN
      check_val("ovr_t4", overrun_o, 4'b0010);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      check_val("ovr_clr1", overrun_o, 4'b0000);
      irq_in = 4'b0100;
      exp_q.push_back(2);
      wait_req("ovr");
      irq_in = 4'b0000;
      repeat (3) step();
      irq_in = 4'b0100;
      repeat (3) step();
      check_val("ovr_set", overrun_o, 4'b0100);
      check_val("ovr_id", irq_id, 2);
      ack_now("ovr");
      step();
      check_val("ovr_absorbed", pend_o, 4'b0000);
      check_val("ovr_sticky", overrun_o, 4'b0100);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      check_val("ovr_clr2", overrun_o, 4'b0000);
      drop_lines();
`endif

      // reset during REQ: everything clears at once, no stale request
      irq_in = 4'b0101;
      exp_q.push_back(2);
      wait_req("t5");
      rst_n = 1'b0;
      #1;
      check_val("t5_req_async", irq_req, 0);
      check_val("t5_pend_async", pend_o, 4'b0000);
      check_val("t5_id_async", irq_id, 0);
      irq_in = 4'b0000;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (6) step();
      check_val("t5_no_stale_req", irq_req, 0);
      check_val("t5_no_stale_pend", pend_o, 4'b0000);

      // ack outside REQ is ignored
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      step();
      check_val("idle_ack", irq_req, 0);

      check_val("sb_leftover", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
